// File: rtl/c17_bist_pkg.sv
// Shared types and constants for the C17 BIST response path.
package c17_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } c17_state_t;

  localparam int unsigned C17_N_OUT  = 2;
  localparam int unsigned C17_MISR_W = 16;
  localparam int unsigned C17_CNT_W  = 10;
  localparam logic [15:0] C17_POLY   = 16'h1021;
  localparam logic [15:0] C17_SEED   = '1;

  // Response bit positions of the C17 primary outputs
  localparam int unsigned C17_IDX_22GAT = 0;
  localparam int unsigned C17_IDX_23GAT = 1;

endpackage

// File: rtl/c17_misr.sv
// Multiple-input signature register: Galois shift with polynomial feedback,
// response XORed into the low bits; load restores the seed.
module c17_misr #(
  parameter int unsigned N_IN = 2,
  parameter int unsigned W    = 16,
  parameter logic [W-1:0] POLY = 16'h1021,
  parameter logic [W-1:0] SEED = '1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            en,
  input  logic [N_IN-1:0] din,
  output logic [W-1:0]    sig
);

  logic [W-1:0] sig_next;

  always_comb begin
    sig_next = {sig[W-2:0], 1'b0} ^ (sig[W-1] ? POLY : '0) ^ W'(din);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    sig <= SEED;
    else if (load) sig <= SEED;
    else if (en)   sig <= sig_next;
  end

endmodule

// File: rtl/c17_resp_compactor.sv
// C17 response compactor: folds accepted response beats into a MISR and
// checks the final signature. Optional X-masking via C17_COMPACTOR_XMASK_EN.
module c17_resp_compactor
  import c17_bist_pkg::*;
#(
  parameter int unsigned N_OUT  = C17_N_OUT,
  parameter int unsigned MISR_W = C17_MISR_W,
  parameter logic [MISR_W-1:0] POLY = MISR_W'(C17_POLY),
  parameter logic [MISR_W-1:0] SEED = '1,
  parameter int unsigned CNT_W  = C17_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_patterns,
  input  logic [MISR_W-1:0] golden_sig,
  input  logic              resp_valid,
  input  logic [N_OUT-1:0]  resp_data,
`ifdef C17_COMPACTOR_XMASK_EN
  input  logic [N_OUT-1:0]  resp_xmask,
`endif
  output logic              resp_ready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature,
  output logic [CNT_W-1:0]  count
);

  c17_state_t state, state_next;

  logic [CNT_W-1:0]  npat_q;
  logic [MISR_W-1:0] golden_q;
  logic              load;
  logic              accept;
  logic              last_beat;
  logic [N_OUT-1:0]  din;

`ifdef C17_COMPACTOR_XMASK_EN
  assign din = resp_data & ~resp_xmask;
`else
  assign din = resp_data;
`endif

  assign last_beat = (count == npat_q - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    accept     = 1'b0;
    resp_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) begin
          load       = 1'b1;
          state_next = (num_patterns != '0) ? RUN : CHECK;
        end
      end
      RUN: begin
        resp_ready = 1'b1;
        busy       = 1'b1;
        accept     = resp_valid;
        if (resp_valid && last_beat) state_next = CHECK;
      end
      CHECK: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      npat_q   <= '0;
      golden_q <= '0;
      pass     <= 1'b0;
    end else if (load) begin
      count    <= '0;
      npat_q   <= num_patterns;
      golden_q <= golden_sig;
      pass     <= 1'b0;
    end else begin
      if (accept)           count <= count + CNT_W'(1);
      if (state == CHECK)   pass  <= (signature == golden_q);
    end
  end

  c17_misr #(
    .N_IN (N_OUT),
    .W    (MISR_W),
    .POLY (POLY),
    .SEED (SEED)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .en    (accept),
    .din   (din),
    .sig   (signature)
  );

endmodule
